// File: rtl/mdu_control.sv
// Iterative multiply/divide unit with function-code decode and HI/LO ownership.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, then a sign-fix cycle.
module mdu_control #(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_out
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    // Function-code decode
    logic is_r, dec_mfhi, dec_mthi, dec_mflo, dec_mtlo, dec_mul, dec_div, is_md;
    logic signed_op, accept_md, accept_mt, busy_int, zero_div;

    always_comb begin
        is_r      = (aluop == 2'b10);
        dec_mfhi  = is_r && (funct == 6'b010000);
        dec_mthi  = is_r && (funct == 6'b010001);
        dec_mflo  = is_r && (funct == 6'b010010);
        dec_mtlo  = is_r && (funct == 6'b010011);
        dec_mul   = is_r && ((funct == 6'b011000) || (funct == 6'b011001));
        dec_div   = is_r && ((funct == 6'b011010) || (funct == 6'b011011));
        is_md     = dec_mfhi || dec_mthi || dec_mflo || dec_mtlo || dec_mul || dec_div;
        // Even funct codes within the mult/div group are the signed variants
        signed_op = (SIGNED_EN != 0) && !funct[0];
        busy_int  = (state_q == S_RUN) || (state_q == S_FIX);
        accept_md = start && (dec_mul || dec_div) && !busy_int;
        accept_mt = start && (dec_mthi || dec_mtlo) && !busy_int;
        zero_div  = dec_div && (rt_val == '0);
    end

    // Operand magnitudes and engine step results
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_upper;
    logic [AW-1:0]    mul_next;
    logic [WIDTH:0]   div_rem_s, div_diff;
    logic             div_ok;
    logic [AW-1:0]    div_next;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        a_neg     = signed_op && rs_val[WIDTH-1];
        b_neg     = signed_op && rt_val[WIDTH-1];
        a_mag     = a_neg ? -rs_val : rs_val;
        b_mag     = b_neg ? -rt_val : rt_val;

        // Multiply: conditionally add multiplicand into upper half, then shift right
        mul_upper = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_next  = {1'b0, mul_upper, acc_q[WIDTH-1:1]};

        // Divide: shift remainder:quotient left, trial-subtract the divisor
        div_rem_s = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_rem_s - {1'b0, opd_q};
        div_ok    = !div_diff[WIDTH];
        div_next  = {1'b0, (div_ok ? div_diff[WIDTH-1:0] : div_rem_s[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ok};

        prod      = acc_q[2*WIDTH-1:0];
        prod_fix  = neg_res_q ? -prod : prod;
        quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // State register and datapath flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opd_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opd_q      <= opd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_md)
                    state_d = zero_div ? S_DONE : S_RUN;
                else
                    state_d = S_IDLE;
            end
            S_RUN:   state_d = (cnt_q == '0) ? S_FIX : S_RUN;
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opd_d      = opd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        if (accept_md) begin
            div_zero_d = zero_div;
            if (zero_div) begin
                hi_d = rs_val;
                lo_d = '1;
            end else begin
                cnt_d     = CW'(WIDTH - 1);
                is_div_d  = dec_div;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                opd_d     = dec_div ? b_mag : a_mag;
                acc_d     = {{(WIDTH + 1){1'b0}}, (dec_div ? a_mag : b_mag)};
            end
        end else if (state_q == S_RUN) begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q - CW'(1);
        end else if (state_q == S_FIX) begin
            if (is_div_q) begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end else begin
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
            end
        end

        // Explicit moves take priority over any engine write on the same edge
        if (accept_mt && dec_mthi) hi_d = rs_val;
        if (accept_mt && dec_mtlo) lo_d = rs_val;
    end

    // Outputs
    always_comb begin
        busy     = busy_int;
        done     = (state_q == S_DONE);
        stall    = start && is_md && busy_int;
        div_zero = div_zero_q;
        hi       = hi_q;
        lo       = lo_q;
        mf_out   = '0;
        if (dec_mfhi) mf_out = hi_q;
        if (dec_mflo) mf_out = lo_q;
    end

endmodule

// File: tb/tb_mdu_control.sv
// Directed bench for mdu_control: signed/unsigned mult and div, divide-by-zero,
// stall against an in-flight op, HI/LO moves and reads, and mid-operation reset.
module tb_mdu_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  aluop = 2'b00;
    logic [5:0]  funct = 6'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;

    logic        busy, done, stall, div_zero;
    logic [31:0] hi, lo, mf_out;
    logic        u_busy, u_done, u_stall, u_div_zero;
    logic [31:0] u_hi, u_lo, u_mf_out;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;

    always #5 clk = ~clk;

    mdu_control #(.WIDTH(32), .SIGNED_EN(1)) dut (
        .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done), .stall(stall),
        .div_zero(div_zero), .hi(hi), .lo(lo), .mf_out(mf_out)
    );

    mdu_control #(.WIDTH(32), .SIGNED_EN(0)) dut_u (
        .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .busy(u_busy), .done(u_done), .stall(u_stall),
        .div_zero(u_div_zero), .hi(u_hi), .lo(u_lo), .mf_out(u_mf_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one R-type instruction for a single accepting edge
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        aluop  = 2'b10;
        funct  = f;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int cycles;
        int edges;

        // Reset state
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        reset = 1'b0;
        tick();

        // Signed mult -2 * 3; accepting edge counted as edge 1
        issue(F_MULT, 32'hFFFFFFFE, 32'd3);
        cycles = 0;
        edges  = 1;
        while (busy && edges < 80) begin
            cycles++;
            tick();
            edges++;
        end
        chk("mul_busy_cyc", cycles, 32'd33);
        chk("mul_done_edge", edges, 32'd34);
        chk("mul_done", {31'd0, done}, 32'd1);
        chk("mul_hi", hi, 32'hFFFFFFFF);
        chk("mul_lo", lo, 32'hFFFFFFFA);
        chk("mul_u_hi", u_hi, 32'h00000002);
        chk("mul_u_lo", u_lo, 32'hFFFFFFFA);
        tick();
        chk("done_pulse", {31'd0, done}, 32'd0);

        // multu of all-ones, then signed mult of the same operands
        issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu_to");
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        issue(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("mults_to");
        chk("mults_hi", hi, 32'h00000000);
        chk("mults_lo", lo, 32'h00000001);
        chk("mult_nse_hi", u_hi, 32'hFFFFFFFE);
        chk("mult_nse_lo", u_lo, 32'h00000001);

        // Signed divides including MIN / -1
        issue(F_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done("div_to");
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done("divovf_to");
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'h00000000);
        issue(F_DIVU, 32'd100, 32'd7);
        wait_done("divu_to");
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // Divide by zero completes in one cycle
        tick();
        issue(F_DIVU, 32'h00001234, 32'd0);
        chk("dz_done", {31'd0, done}, 32'd1);
        chk("dz_busy", {31'd0, busy}, 32'd0);
        chk("dz_hi", hi, 32'h00001234);
        chk("dz_lo", lo, 32'hFFFFFFFF);
        chk("dz_flag", {31'd0, div_zero}, 32'd1);
        issue(F_MULT, 32'd2, 32'd3);
        chk("dz_clear", {31'd0, div_zero}, 32'd0);
        wait_done("mul23_to");
        chk("mul23_lo", lo, 32'd6);

        // mflo while the engine runs: stalled until the DONE cycle
        tick();
        issue(F_MULTU, 32'h10, 32'h10);
        tick();
        tick();
        tick();
        tick();
        aluop = 2'b10;
        funct = F_MFLO;
        start = 1'b1;
        #1;
        chk("stall_on", {31'd0, stall}, 32'd1);
        cycles = 0;
        while (stall && cycles < 80) begin
            tick();
            cycles++;
        end
        chk("stall_done", {31'd0, done}, 32'd1);
        chk("stall_mf", mf_out, 32'h00000100);
        start = 1'b0;
        tick();

        // mthi while idle, then read back through mf_out
        issue(F_MTHI, 32'hA5A5A5A5, 32'd0);
        chk("mthi_hi", hi, 32'hA5A5A5A5);
        funct = F_MFHI;
        #1;
        chk("mfhi_out", mf_out, 32'hA5A5A5A5);
        aluop = 2'b00;
        #1;
        chk("mf_noop", mf_out, 32'd0);

        // Reset in the middle of RUN discards the operation
        issue(F_MULTU, 32'h1234, 32'h5678);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_hi", hi, 32'd0);
        chk("mrst_lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        issue(F_MULTU, 32'd6, 32'd7);
        wait_done("m67_to");
        chk("m67_lo", lo, 32'd42);
        chk("m67_hi", hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
